scr1_csr_access_ctrl: RTL and testbench

- Initiator side of the machine-mode CSR file read/write port.
- Accepts one decoded Zicsr instruction at a time: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI or CSRRCI.
- Sequences the accesses on the CSR file port: a registered read, then a separate write, because the CSR file gives write priority over read and returns read data one cycle after en_read.
- Returns the old CSR value for rd, or flags an illegal instruction.
- Sits between the execute stage and the CSR register file.

---
 rtl/scr1_csr_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_scr1_csr_access_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_csr_access_ctrl.sv
// rtl/scr1_csr_access_ctrl.sv - Zicsr instruction sequencer driving the machine-mode CSR file port
module scr1_csr_access_ctrl #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 32
) (
    input  logic              clk_in,
    input  logic              rst_ni,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [11:0]       req_csr,
    input  logic [XLEN-1:0]   req_rs1_data,
    input  logic [4:0]        req_rs1_idx,
    input  logic [4:0]        req_rd,
    output logic [CSR_AW-1:0] csr_address,
    output logic              csr_en_read,
    output logic              csr_en_write,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [4:0]        rsp_rd,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_illegal
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   src_q;
    logic [XLEN-1:0]   old_q;
    logic [11:0]       csr_q;
    logic              do_write_q;

    logic              accept;
    logic [XLEN-1:0]   src;
    logic              do_read;
    logic              do_write;
    logic              csr_known;
    logic              illegal;

    function automatic logic [XLEN-1:0] merge(input logic [1:0] op,
                                              input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] val);
        case (op)
            2'b01:   merge = val;
            2'b10:   merge = old | val;
            default: merge = old & ~val;
        endcase
    endfunction

    function automatic logic [CSR_AW-1:0] ext_addr(input logic [11:0] num);
        ext_addr = {{(CSR_AW-12){1'b0}}, num};
    endfunction

    always_comb begin
        accept   = req_valid && req_ready;
        src      = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_data;
        do_read  = !(req_funct3[1:0] == 2'b01 && req_rd == 5'd0);
        do_write = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
        case (req_csr)
            12'h301, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h342, 12'h300, 12'h305,
            12'h341, 12'h344, 12'h304, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h306:
                csr_known = 1'b1;
            default:
                csr_known = 1'b0;
        endcase
        illegal = (req_funct3[1:0] == 2'b00) || !csr_known
                  || (do_write && req_csr[11:10] == 2'b11);
    end

    // All outputs are registered; each state arms the strobes of the state it enters.
    always_ff @(posedge clk_in or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            csr_address  <= '0;
            csr_en_read  <= 1'b0;
            csr_en_write <= 1'b0;
            csr_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_rd       <= '0;
            rsp_data     <= '0;
            rsp_illegal  <= 1'b0;
            op_q         <= '0;
            src_q        <= '0;
            old_q        <= '0;
            csr_q        <= '0;
            do_write_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready  <= 1'b0;
                        op_q       <= req_funct3[1:0];
                        src_q      <= src;
                        csr_q      <= req_csr;
                        do_write_q <= do_write;
                        rsp_rd     <= req_rd;
                        old_q      <= '0;
                        if (illegal) begin
                            state       <= RSP;
                            rsp_valid   <= 1'b1;
                            rsp_illegal <= 1'b1;
                            rsp_data    <= '0;
                        end else if (do_read) begin
                            state       <= RD;
                            csr_en_read <= 1'b1;
                            csr_address <= ext_addr(req_csr);
                        end else begin
                            state        <= WR;
                            csr_en_write <= 1'b1;
                            csr_address  <= ext_addr(req_csr);
                            csr_wdata    <= merge(req_funct3[1:0], '0, src);
                        end
                    end
                end
                RD: begin
                    state       <= CAP;
                    csr_en_read <= 1'b0;
                    csr_address <= '0;
                end
                CAP: begin
                    // csr_rdata is only valid now, so the write data is merged from it directly.
                    old_q <= csr_rdata;
                    if (do_write_q) begin
                        state        <= WR;
                        csr_en_write <= 1'b1;
                        csr_address  <= ext_addr(csr_q);
                        csr_wdata    <= merge(op_q, csr_rdata, src_q);
                    end else begin
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= csr_rdata;
                    end
                end
                WR: begin
                    state        <= RSP;
                    csr_en_write <= 1'b0;
                    csr_address  <= '0;
                    csr_wdata    <= '0;
                    rsp_valid    <= 1'b1;
                    rsp_data     <= old_q;
                end
                RSP: begin
                    if (rsp_ready) begin
                        state       <= IDLE;
                        req_ready   <= 1'b1;
                        rsp_valid   <= 1'b0;
                        rsp_illegal <= 1'b0;
                        rsp_data    <= '0;
                        rsp_rd      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_csr_access_ctrl.sv
// tb/tb_scr1_csr_access_ctrl.sv - scoreboard bench for scr1_csr_access_ctrl with a CSR file model
module tb_scr1_csr_access_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = '0;
    logic [11:0] req_csr = '0;
    logic [31:0] req_rs1_data = '0;
    logic [4:0]  req_rs1_idx = '0;
    logic [4:0]  req_rd = '0;
    logic [31:0] csr_address;
    logic        csr_en_read;
    logic        csr_en_write;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_illegal;

    scr1_csr_access_ctrl #(.XLEN(32), .CSR_AW(32)) dut (
        .clk_in(clk_in), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_csr(req_csr), .req_rs1_data(req_rs1_data), .req_rs1_idx(req_rs1_idx),
        .req_rd(req_rd), .csr_address(csr_address), .csr_en_read(csr_en_read),
        .csr_en_write(csr_en_write), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
        .rsp_data(rsp_data), .rsp_illegal(rsp_illegal)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
    } rsp_t;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    rsp_t        rexp;
    wr_t         wexp;
    logic [31:0] file_mem [0:4095];
    logic [31:0] ref_mem  [0:4095];
    logic [11:0] legal [0:15] = '{12'h301, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h342,
                                  12'h300, 12'h305, 12'h341, 12'h344, 12'h304, 12'hB00,
                                  12'hB80, 12'hB02, 12'hB82, 12'h306};
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CSR file: registered read one cycle after en_read, write takes priority
    always @(posedge clk_in) begin
        if (csr_en_write)
            file_mem[csr_address[11:0]] <= csr_wdata;
        else if (csr_en_read)
            csr_rdata <= file_mem[csr_address[11:0]];
    end

    always @(negedge clk_in) begin
        if (rst_ni) begin
            chk("strobe_excl", {csr_en_read, csr_en_write} == 2'b11, 0);
            if (!csr_en_read && !csr_en_write)
                chk("addr_idle", csr_address, 0);
            if (csr_en_write) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    wexp = wr_q.pop_front();
                    chk("wr_addr", csr_address, {20'h0, wexp.a});
                    chk("wr_data", csr_wdata, wexp.d);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    rexp = rsp_q.pop_front();
                    chk("rsp_rd", rsp_rd, rexp.rd);
                    chk("rsp_data", rsp_data, rexp.data);
                    chk("rsp_illegal", rsp_illegal, rexp.ill);
                end
            end
        end
    end

    function automatic bit is_legal(input logic [11:0] c);
        is_legal = 1'b0;
        for (int i = 0; i < 16; i++)
            if (legal[i] == c) is_legal = 1'b1;
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [11:0] csr, input logic [31:0] rs1d,
                         input logic [4:0] idx, input logic [4:0] rd, input int hold,
                         input bit abort_in_wr);
        logic [31:0] src, old, nv, d0;
        bit          dr, dw, ill;
        int          lat, n, rdc, wrc;
        src = f3[2] ? {27'h0, idx} : rs1d;
        dr  = !(f3[1:0] == 2'b01 && rd == 5'd0);
        dw  = (f3[1:0] == 2'b01) || (idx != 5'd0);
        ill = (f3[1:0] == 2'b00) || !is_legal(csr) || (dw && csr[11:10] == 2'b11);
        old = (!ill && dr) ? ref_mem[csr] : 32'h0;
        nv  = (f3[1:0] == 2'b01) ? src : (f3[1:0] == 2'b10) ? (old | src) : (old & ~src);
        lat = ill ? 1 : (dr && dw) ? 4 : dr ? 3 : 2;
        rsp_q.push_back('{rd: rd, data: old, ill: ill});
        if (!ill && dw) begin
            wr_q.push_back('{a: csr, d: nv});
            if (!abort_in_wr) ref_mem[csr] = nv;
        end

        @(negedge clk_in);
        chk("req_ready_idle", req_ready, 1);
        req_funct3 = f3; req_csr = csr; req_rs1_data = rs1d; req_rs1_idx = idx; req_rd = rd;
        req_valid = 1'b1;
        @(posedge clk_in);
        #1 req_valid = 1'b0;

        rdc = 0; wrc = 0; n = 0;
        while (n < 20) begin
            @(negedge clk_in);
            n++;
            if (csr_en_read) rdc = n;
            if (csr_en_write) wrc = n;
            if (abort_in_wr && csr_en_write) break;
            if (rsp_valid) break;
        end

        if (abort_in_wr) begin
            chk("abort_wr_cyc", wrc, 3);
            #1 rst_ni = 1'b0;
            #1;
            chk("abort_en_write", csr_en_write, 0);
            chk("abort_req_ready", req_ready, 1);
            chk("abort_rsp_valid", rsp_valid, 0);
            void'(rsp_q.pop_back());
            @(posedge clk_in);
            #2 rst_ni = 1'b1;
            repeat (2) begin
                @(negedge clk_in);
                chk("post_rst_ready", req_ready, 1);
                chk("post_rst_valid", rsp_valid, 0);
                chk("post_rst_no_wr", csr_en_write, 0);
            end
            return;
        end

        chk("latency", n, lat);
        chk("rd_strobe_cyc", rdc, (!ill && dr) ? 1 : 0);
        chk("wr_strobe_cyc", wrc, (!ill && dw) ? (dr ? 3 : 1) : 0);
        if (!rsp_valid) begin
            rsp_q.delete();
            wr_q.delete();
            return;
        end
        d0 = rsp_data;
        repeat (hold) begin
            @(negedge clk_in);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, d0);
        end
        @(posedge clk_in);
        #1 rsp_ready = 1'b1;
        @(posedge clk_in);
        #1 rsp_ready = 1'b0;
        @(negedge clk_in);
        chk("ready_after_rsp", req_ready, 1);
        chk("valid_after_rsp", rsp_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            file_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        file_mem[12'h305] = 32'h0000_0040; ref_mem[12'h305] = 32'h0000_0040;
        file_mem[12'h304] = 32'h0000_0888; ref_mem[12'h304] = 32'h0000_0888;
        file_mem[12'h300] = 32'h0000_1888; ref_mem[12'h300] = 32'h0000_1888;
        file_mem[12'h341] = 32'h5555_5555; ref_mem[12'h341] = 32'h5555_5555;
        file_mem[12'hF14] = 32'h0000_0003; ref_mem[12'hF14] = 32'h0000_0003;

        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_en_read", csr_en_read, 0);
        chk("rst_en_write", csr_en_write, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_illegal", rsp_illegal, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_rd", rsp_rd, 0);
        chk("rst_address", csr_address, 0);
        chk("rst_wdata", csr_wdata, 0);
        @(negedge clk_in);
        rst_ni = 1'b1;

        issue(3'b001, 12'h305, 32'h8000_0100, 5'd1, 5'd5, 0, 0);
        issue(3'b010, 12'h304, 32'hFFFF_FFFF, 5'd0, 5'd7, 0, 0);
        issue(3'b111, 12'h300, 32'hDEAD_BEEF, 5'd8, 5'd2, 0, 0);
        issue(3'b001, 12'h341, 32'h0000_1234, 5'd3, 5'd0, 0, 0);
        issue(3'b001, 12'hF11, 32'h0000_0001, 5'd1, 5'd4, 0, 0);
        issue(3'b010, 12'h7C0, 32'h0000_0000, 5'd0, 5'd4, 0, 0);
        issue(3'b100, 12'h300, 32'h0000_0000, 5'd0, 5'd4, 0, 0);
        issue(3'b010, 12'hF14, 32'h0000_0000, 5'd0, 5'd9, 0, 0);
        issue(3'b110, 12'h300, 32'h0000_0000, 5'd6, 5'd1, 0, 0);
        issue(3'b011, 12'h305, 32'h0000_00C0, 5'd2, 5'd3, 3, 0);
        issue(3'b001, 12'h305, 32'h1111_0000, 5'd1, 5'd1, 0, 1);
        issue(3'b010, 12'h305, 32'h0000_0000, 5'd0, 5'd8, 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [2:0] f;
            f = 3'($urandom_range(1, 7));
            if (f == 3'b100) f = 3'b101;
            issue(f, legal[$urandom_range(0, 15)], $urandom(), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 2), 0);
        end

        repeat (3) @(negedge clk_in);
        chk("rsp_q_drained", rsp_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
